// File: rtl/ramp_sweep_analyzer.sv
// Ramp sweep analyzer: tracks the extrema of a measured signal over one ramp half-sweep
// and reports the values and the ramp positions where they occurred.
module ramp_sweep_analyzer #(
  parameter int unsigned R     = 14,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                half_sel,
  input  logic signed [R-1:0] ramp_in,
  input  logic signed [R-1:0] sig_in,
  input  logic                trig_low,
  input  logic                trig_hig,
  output logic signed [R-1:0] max_val,
  output logic signed [R-1:0] max_pos,
  output logic signed [R-1:0] min_val,
  output logic signed [R-1:0] min_pos,
  output logic [CNT_W-1:0]    sweep_len,
  output logic                valid,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ARM, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic signed [R-1:0] s_ramp_q, s_sig_q;
  logic                s_tlo_q, s_thi_q;
  logic                hsel_q, hsel_d;
  logic signed [R-1:0] trk_max_q, trk_max_d, trk_max_pos_q, trk_max_pos_d;
  logic signed [R-1:0] trk_min_q, trk_min_d, trk_min_pos_q, trk_min_pos_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [R-1:0] max_val_q, max_val_d, max_pos_q, max_pos_d;
  logic signed [R-1:0] min_val_q, min_val_d, min_pos_q, min_pos_d;
  logic [CNT_W-1:0]    sweep_len_q, sweep_len_d;
  logic                valid_q, valid_d, busy_q, busy_d;
  logic                start_c, stop_c;

  // Next-state, tracker and result logic
  always_comb begin
    state_d       = state_q;
    hsel_d        = hsel_q;
    trk_max_d     = trk_max_q;
    trk_max_pos_d = trk_max_pos_q;
    trk_min_d     = trk_min_q;
    trk_min_pos_d = trk_min_pos_q;
    cnt_d         = cnt_q;
    max_val_d     = max_val_q;
    max_pos_d     = max_pos_q;
    min_val_d     = min_val_q;
    min_pos_d     = min_pos_q;
    sweep_len_d   = sweep_len_q;
    valid_d       = 1'b0;

    // Sweep direction is frozen once a scan is under way
    if (state_q == IDLE || state_q == ARM) begin
      hsel_d = half_sel;
    end
    start_c = hsel_d ? s_thi_q : s_tlo_q;
    stop_c  = hsel_d ? s_tlo_q : s_thi_q;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (start_c) begin
            state_d       = SCAN;
            trk_max_d     = s_sig_q;
            trk_min_d     = s_sig_q;
            trk_max_pos_d = s_ramp_q;
            trk_min_pos_d = s_ramp_q;
            cnt_d         = CNT_W'(1);
          end
        end
        SCAN: begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (s_sig_q > trk_max_q) begin
            trk_max_d     = s_sig_q;
            trk_max_pos_d = s_ramp_q;
          end
          if (s_sig_q < trk_min_q) begin
            trk_min_d     = s_sig_q;
            trk_min_pos_d = s_ramp_q;
          end
          // Results are published on entry to DONE so they appear with valid
          if (stop_c) begin
            state_d     = DONE;
            max_val_d   = trk_max_d;
            max_pos_d   = trk_max_pos_d;
            min_val_d   = trk_min_d;
            min_pos_d   = trk_min_pos_d;
            sweep_len_d = cnt_d;
            valid_d     = 1'b1;
          end
        end
        DONE:    state_d = ARM;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == SCAN);
  end

  // Input stage and state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      s_ramp_q      <= '0;
      s_sig_q       <= '0;
      s_tlo_q       <= 1'b0;
      s_thi_q       <= 1'b0;
      hsel_q        <= 1'b0;
      trk_max_q     <= '0;
      trk_max_pos_q <= '0;
      trk_min_q     <= '0;
      trk_min_pos_q <= '0;
      cnt_q         <= '0;
      max_val_q     <= '0;
      max_pos_q     <= '0;
      min_val_q     <= '0;
      min_pos_q     <= '0;
      sweep_len_q   <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_ramp_q      <= ramp_in;
      s_sig_q       <= sig_in;
      s_tlo_q       <= trig_low;
      s_thi_q       <= trig_hig;
      hsel_q        <= hsel_d;
      trk_max_q     <= trk_max_d;
      trk_max_pos_q <= trk_max_pos_d;
      trk_min_q     <= trk_min_d;
      trk_min_pos_q <= trk_min_pos_d;
      cnt_q         <= cnt_d;
      max_val_q     <= max_val_d;
      max_pos_q     <= max_pos_d;
      min_val_q     <= min_val_d;
      min_pos_q     <= min_pos_d;
      sweep_len_q   <= sweep_len_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
    end
  end

  assign max_val   = max_val_q;
  assign max_pos   = max_pos_q;
  assign min_val   = min_val_q;
  assign min_pos   = min_pos_q;
  assign sweep_len = sweep_len_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule
